axi_read_master: RTL
====================

// Module: axi_read_master
// PURPOSE
//   AXI4 read initiator. Accepts a (base address, beat count) command and splits it into
//   INCR AR bursts on a full AXI manager port. Buffers the returned R beats in an internal
//   FIFO and presents them as a valid/ready stream. Used by the boot/copy path to pull
//   images out of ROM/RAM subordinates on the SoC crossbar. Write channels are tied off.
// PARAMETERS
//   req_t          soc_pkg::m_req_t   AXI manager request struct (AW/W/B/AR/R fields)
//   resp_t         soc_pkg::m_resp_t  AXI manager response struct
//   ARID           '0                 constant ar.id driven on every burst
//   ARPROT         3'b000             constant ar.prot (prot[1] selects secure/non-secure bank)
//   MAX_BURST_LEN  16                 max beats per burst, 1..256
//   FIFO_DEPTH     16                 R-beat buffer depth, power of 2, >= MAX_BURST_LEN
// PORTS
//   clk_i         in   1         clock
//   arst_ni       in   1         asynchronous active-low reset
//   cmd_valid_i   in   1         command valid
//   cmd_ready_o   out  1         command accepted (high only in IDLE)
//   cmd_addr_i    in   64        byte base address; low log2(DW/8) bits forced to 0
//   cmd_beats_i   in   16        total beats to read; 0 = no bus traffic
//   req_o         out  req_t     AXI request to crossbar
//   resp_i        in   resp_t    AXI response from crossbar
//   data_o        out  DW        stream data (DW = $bits(resp_i.r.data))
//   data_valid_o  out  1         stream valid
//   data_ready_i  in   1         stream ready
//   data_last_o   out  1         final beat of the command
//   done_o        out  1         1-cycle pulse when the last beat leaves the stream port
//   err_o         out  1         sticky: any rresp != OKAY since last accepted command
// BEHAVIOUR
//   Reset: state IDLE, counters/FIFO empty. Outputs: cmd_ready_o=1, ar_valid=0,
//     r_ready=0, data_valid_o=0, done_o=0, err_o=0.
//   Tie-offs: aw_valid=0, w_valid=0, all AW/W fields 0, b_ready=1.
//   AR fields: burst=INCR(2'b01), size=$clog2(DW/8), lock/cache/qos/region/user/atop=0.
//   FSM
//     IDLE   cmd_valid_i&cmd_ready_o: latch addr/beats, clear err_o.
//            beats==0 -> DONE, else ARREQ.
//     ARREQ  len = min(remaining, MAX_BURST_LEN, beats to next 4 KiB boundary) - 1.
//            ar_valid asserted only when FIFO free slots >= len+1 (credit rule; R is never
//            stalled by a full FIFO). Fields held stable while ar_valid & !ar_ready.
//            On handshake: addr += (len+1)*DW/8, remaining -= len+1 -> RDATA.
//     RDATA  r_ready=1. Each r handshake pushes the beat into the FIFO.
//            On r.last: remaining==0 -> DRAIN, else ARREQ.
//     DRAIN  wait for FIFO empty -> IDLE. done_o pulses on the final stream handshake.
//     DONE   (beats==0 only) done_o=1 for one cycle -> IDLE.
//   One outstanding burst at a time. Next AR may assert the cycle after r.last.
//   r.id is not checked.
//   Stream: data_valid_o = !fifo_empty. data_last_o is high on the beat where the popped
//     count == latched beats. Pop only on data_valid_o & data_ready_i.
//   Boundary cases
//     Simultaneous FIFO push and pop: both take effect; count unchanged.
//     FIFO full is unreachable by construction; an assertion guards it.
//     cmd_valid_i outside IDLE: ignored. Reset mid-burst: FSM and FIFO cleared at once;
//       the crossbar/subordinate must be reset together with this block.
//     Address arithmetic is 64-bit modulo.
// CONFIGURATION
//   AXI_READ_MASTER_ERR_ABORT_EN
//     defined:   on the first rresp!=OKAY, finish the current burst (keep r_ready) and issue
//                no further AR. remaining forced to 0; data_last_o on the last beat actually
//                received; done_o still pulses.
//     undefined: err_o set, all bursts still issued, bad beats forwarded unchanged.
// STRUCTURE
//   soc_pkg: AXI_BURST_INCR, AXI_RESP_OKAY constants; 4 KiB page constant.
//   Sub-module axi_read_master_fifo: sync FIFO, WIDTH/DEPTH params, push/pop/count/empty/full.
// TESTING (DW=64, MAX_BURST_LEN=16, FIFO_DEPTH=16 unless noted)
//   cmd 0x1000/4 -> one AR addr=0x1000 len=3 size=3; 4 stream beats; last on beat 4;
//     done 1 cycle after.
//   cmd 0x1000/40 -> ARs len 15,15,7 at 0x1000,0x1080,0x1100; 40 beats in order.
//   cmd 0x1FF0/4 -> AR 0x1FF0 len=1, then AR 0x2000 len=1 (4 KiB split).
//   data_ready_i=0, cmd 0x0/32 -> first burst fills FIFO; second AR withheld until 16 pops;
//     r_ready never stalls.
//   rresp=SLVERR on beat 2 of 40 -> err_o=1. ERR_ABORT_EN: 16 beats, no 2nd AR.
//     Without macro: 40 beats.
//   cmd beats=0 -> no ar_valid, done_o pulse, cmd_ready_o back 2 cycles later.

Source files
------------

// File: rtl/axi_read_master_pkg.sv
// Local types and helpers for the AXI read initiator.
package axi_read_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARREQ = 3'd1,
        ST_RDATA = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } arm_state_e;

    function automatic logic [16:0] min_beats(input logic [16:0] a, input logic [16:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/soc_pkg.sv
// Shared SoC AXI4 definitions: channel structs, manager port bundles and protocol constants.
package soc_pkg;

    localparam int unsigned AXI_ADDR_W = 64;
    localparam int unsigned AXI_DATA_W = 64;
    localparam int unsigned AXI_ID_W   = 4;
    localparam int unsigned AXI_USER_W = 1;

    localparam logic [1:0]  AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0]  AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0]  AXI_RESP_SLVERR = 2'b10;
    localparam logic [12:0] AXI_PAGE_BYTES  = 13'd4096;

    typedef logic [AXI_DATA_W-1:0] axi_data_t;

    typedef struct packed {
        logic [AXI_ID_W-1:0]   id;
        logic [AXI_ADDR_W-1:0] addr;
        logic [7:0]            len;
        logic [2:0]            size;
        logic [1:0]            burst;
        logic                  lock;
        logic [3:0]            cache;
        logic [2:0]            prot;
        logic [3:0]            qos;
        logic [3:0]            region;
        logic [5:0]            atop;
        logic [AXI_USER_W-1:0] user;
    } axi_aw_t;

    typedef struct packed {
        logic [AXI_DATA_W-1:0]   data;
        logic [AXI_DATA_W/8-1:0] strb;
        logic                    last;
        logic [AXI_USER_W-1:0]   user;
    } axi_w_t;

    typedef struct packed {
        logic [AXI_ID_W-1:0]   id;
        logic [1:0]            resp;
        logic [AXI_USER_W-1:0] user;
    } axi_b_t;

    typedef struct packed {
        logic [AXI_ID_W-1:0]   id;
        logic [AXI_ADDR_W-1:0] addr;
        logic [7:0]            len;
        logic [2:0]            size;
        logic [1:0]            burst;
        logic                  lock;
        logic [3:0]            cache;
        logic [2:0]            prot;
        logic [3:0]            qos;
        logic [3:0]            region;
        logic [AXI_USER_W-1:0] user;
    } axi_ar_t;

    typedef struct packed {
        logic [AXI_ID_W-1:0]   id;
        logic [AXI_DATA_W-1:0] data;
        logic [1:0]            resp;
        logic                  last;
        logic [AXI_USER_W-1:0] user;
    } axi_r_t;

    typedef struct packed {
        axi_aw_t aw;
        logic    aw_valid;
        axi_w_t  w;
        logic    w_valid;
        logic    b_ready;
        axi_ar_t ar;
        logic    ar_valid;
        logic    r_ready;
    } m_req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        logic    b_valid;
        axi_b_t  b;
        logic    r_valid;
        axi_r_t  r;
    } m_resp_t;

endpackage

// File: rtl/axi_read_master_fifo.sv
// Synchronous FIFO buffering returned R beats, plus its overflow checker.
module axi_read_master_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW   = AW + 1
) (
    input  logic             clk_i,
    input  logic             arst_ni,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wptr_r;
    logic [AW-1:0]    rptr_r;
    logic [CW-1:0]    count_r;
    logic             push_s;
    logic             pop_s;

    assign empty  = (count_r == CW'(0));
    assign full   = (count_r == CW'(DEPTH));
    assign count  = count_r;
    assign rdata  = mem_r[rptr_r];
    assign push_s = push & ~full;
    assign pop_s  = pop & ~empty;

    // Data storage; contents are don't-care until written.
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            mem_r[wptr_r] <= wdata;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            wptr_r  <= AW'(0);
            rptr_r  <= AW'(0);
            count_r <= CW'(0);
        end else begin
            if (push_s) wptr_r <= wptr_r + AW'(1);
            if (pop_s)  rptr_r <= rptr_r + AW'(1);
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    axi_read_master_fifo_chk u_chk (
        .clk_i   (clk_i),
        .arst_ni (arst_ni),
        .push    (push),
        .full    (full)
    );

endmodule

module axi_read_master_fifo_chk (
    input logic clk_i,
    input logic arst_ni,
    input logic push,
    input logic full
);

    // The AR credit rule reserves space before each burst, so a push can never meet a full FIFO.
    assert property (@(posedge clk_i) disable iff (!arst_ni) !(push && full));

endmodule

// File: rtl/axi_read_master.sv
// AXI4 read initiator: splits (addr, beats) commands into INCR bursts and streams the data out.
// Optional AXI_READ_MASTER_ERR_ABORT_EN: stop issuing bursts after the first error response.
module axi_read_master
    import soc_pkg::*;
    import axi_read_master_pkg::*;
#(
    parameter type               req_t         = soc_pkg::m_req_t,
    parameter type               resp_t        = soc_pkg::m_resp_t,
    parameter logic [AXI_ID_W-1:0] ARID        = '0,
    parameter logic [2:0]        ARPROT        = 3'b000,
    parameter int unsigned       MAX_BURST_LEN = 16,
    parameter int unsigned       FIFO_DEPTH    = 16,
    localparam int unsigned      DW            = $bits(axi_data_t)
) (
    input  logic          clk_i,
    input  logic          arst_ni,
    input  logic          cmd_valid_i,
    output logic          cmd_ready_o,
    input  logic [63:0]   cmd_addr_i,
    input  logic [15:0]   cmd_beats_i,
    output req_t          req_o,
    input  resp_t         resp_i,
    output logic [DW-1:0] data_o,
    output logic          data_valid_o,
    input  logic          data_ready_i,
    output logic          data_last_o,
    output logic          done_o,
    output logic          err_o
);

    localparam int unsigned SIZE      = $clog2(DW/8);
    localparam int unsigned CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [63:0] ADDR_MASK = 64'(DW/8 - 1);

    arm_state_e    state_r;
    logic [63:0]   addr_r;
    logic [15:0]   remaining_r;
    logic [15:0]   beats_r;
    logic [15:0]   popped_r;
    logic [15:0]   pushed_r;
    logic          err_r;
    logic          ar_valid_r;
    logic [63:0]   ar_addr_r;
    logic [7:0]    ar_len_r;
    logic          r_ready_r;
    logic          done_r;

    logic [CW-1:0] fifo_count_s;
    logic          fifo_empty_s;
    logic          fifo_full_s;
    logic [16:0]   page_beats_s;
    logic [16:0]   burst_beats_s;
    logic [16:0]   free_s;
    logic          r_hs_s;
    logic          r_err_s;
    logic          pop_s;
    logic          last_s;
    logic          abort_s;
    logic          unused_s;

    // Next burst size (page-, length- and remaining-limited) and FIFO credit.
    always_comb begin
        page_beats_s  = 17'((AXI_PAGE_BYTES - {1'b0, addr_r[11:0]}) >> SIZE);
        burst_beats_s = min_beats(min_beats({1'b0, remaining_r}, 17'(MAX_BURST_LEN)), page_beats_s);
        free_s        = 17'(FIFO_DEPTH) - 17'(fifo_count_s);
        r_hs_s        = resp_i.r_valid & r_ready_r;
        r_err_s       = r_hs_s & (resp_i.r.resp != AXI_RESP_OKAY);
        pop_s         = ~fifo_empty_s & data_ready_i;
        last_s        = (popped_r + 16'd1 == beats_r);
`ifdef AXI_READ_MASTER_ERR_ABORT_EN
        abort_s       = err_r | r_err_s;
`else
        abort_s       = 1'b0;
`endif
    end

    // Command sequencing, burst issue and stream bookkeeping.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_r     <= ST_IDLE;
            addr_r      <= 64'd0;
            remaining_r <= 16'd0;
            beats_r     <= 16'd0;
            popped_r    <= 16'd0;
            pushed_r    <= 16'd0;
            err_r       <= 1'b0;
            ar_valid_r  <= 1'b0;
            ar_addr_r   <= 64'd0;
            ar_len_r    <= 8'd0;
            r_ready_r   <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (pop_s)            popped_r <= popped_r + 16'd1;
            if (pop_s && last_s)  done_r   <= 1'b1;
            if (r_hs_s)           pushed_r <= pushed_r + 16'd1;
            if (r_err_s)          err_r    <= 1'b1;
            case (state_r)
                ST_IDLE: begin
                    if (cmd_valid_i) begin
                        addr_r      <= cmd_addr_i & ~ADDR_MASK;
                        beats_r     <= cmd_beats_i;
                        remaining_r <= cmd_beats_i;
                        popped_r    <= 16'd0;
                        pushed_r    <= 16'd0;
                        err_r       <= 1'b0;
                        state_r     <= (cmd_beats_i == 16'd0) ? ST_DONE : ST_ARREQ;
                    end
                end
                ST_ARREQ: begin
                    if (ar_valid_r) begin
                        if (resp_i.ar_ready) begin
                            ar_valid_r  <= 1'b0;
                            r_ready_r   <= 1'b1;
                            addr_r      <= addr_r + ((64'(ar_len_r) + 64'd1) << SIZE);
                            remaining_r <= remaining_r - (16'(ar_len_r) + 16'd1);
                            state_r     <= ST_RDATA;
                        end
                    end else if (free_s >= burst_beats_s) begin
                        ar_valid_r <= 1'b1;
                        ar_addr_r  <= addr_r;
                        ar_len_r   <= 8'(burst_beats_s - 17'd1);
                    end
                end
                ST_RDATA: begin
                    if (r_hs_s) begin
                        if (abort_s) remaining_r <= 16'd0;
                        if (resp_i.r.last) begin
                            r_ready_r <= 1'b0;
                            if (abort_s) begin
                                // Shrink the command so data_last_o marks the final beat received.
                                beats_r <= pushed_r + 16'd1;
                                state_r <= ST_DRAIN;
                            end else if (remaining_r == 16'd0) begin
                                state_r <= ST_DRAIN;
                            end else begin
                                state_r <= ST_ARREQ;
                            end
                        end
                    end
                end
                ST_DRAIN: begin
                    if (fifo_empty_s) state_r <= ST_IDLE;
                end
                ST_DONE: begin
                    done_r  <= 1'b1;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // AXI request: write channels tied off, AR driven from the burst registers.
    always_comb begin
        req_o           = '0;
        req_o.b_ready   = 1'b1;
        req_o.ar.id     = ARID;
        req_o.ar.addr   = ar_addr_r;
        req_o.ar.len    = ar_len_r;
        req_o.ar.size   = 3'(SIZE);
        req_o.ar.burst  = AXI_BURST_INCR;
        req_o.ar.prot   = ARPROT;
        req_o.ar_valid  = ar_valid_r;
        req_o.r_ready   = r_ready_r;
    end

    axi_read_master_fifo #(
        .WIDTH (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .arst_ni (arst_ni),
        .push    (r_hs_s),
        .wdata   (resp_i.r.data),
        .pop     (pop_s),
        .rdata   (data_o),
        .count   (fifo_count_s),
        .empty   (fifo_empty_s),
        .full    (fifo_full_s)
    );

    assign cmd_ready_o  = (state_r == ST_IDLE);
    assign data_valid_o = ~fifo_empty_s;
    assign data_last_o  = ~fifo_empty_s & last_s;
    assign done_o       = done_r;
    assign err_o        = err_r;
    assign unused_s     = ^{resp_i.aw_ready, resp_i.w_ready, resp_i.b_valid, resp_i.b,
                            resp_i.r.id, resp_i.r.user, fifo_full_s};

endmodule
